// File: rtl/boa_pkg.sv
// Shared constants and types for the boa memory bus.
//   max_ports : most bus ports one multi-port RAM can arbitrate
//   grant_w   : width of a port index (clog2 of max_ports)
//   grant_t   : port index type
//   pend_t    : record of the port whose read data returns next cycle
//   next_ptr  : round-robin pointer advance with wrap at n
package boa_pkg;

   localparam int max_ports = 8;
   localparam int grant_w   = $clog2(max_ports);

   typedef logic [grant_w-1:0] grant_t;

   typedef struct packed {
      logic   valid;
      grant_t idx;
   } pend_t;

   // Port after g, wrapping from n-1 back to 0.
   function automatic grant_t next_ptr(grant_t g, int n);
      if (int'(g) >= n - 1) return '0;
      return g + grant_t'(1);
   endfunction

endpackage

// File: rtl/boa_mem_bus.sv
// Memory bus between a master and a memory.
//   re    : read request
//   we    : per-byte write enables (any bit set is a write request)
//   addr  : byte address
//   wdata : write data
//   rdata : read data, valid the cycle after the access is accepted
//   ready : request accepted this cycle (high whenever idle)
// Handshake: a request is accepted in a cycle where it is presented
// with ready high; holding it afterwards issues another request.
interface boa_mem_bus;
   logic        re;
   logic [3:0]  we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;

   modport MEM (input re, we, addr, wdata, output rdata, ready);
   modport CPU (output re, we, addr, wdata, input rdata, ready);
endinterface

// File: rtl/raw_block_ram.sv
// Single-port byte-lane block RAM, read-first, one cycle read latency.
//   clk   : clock
//   en    : access enable; rdata updates only on enabled cycles
//   we    : per-lane write enables
//   addr  : word address
//   wdata : write data
//   rdata : registered read data (word contents before any write)
// Storage has no reset. Preloading from init_file is left to the
// implementation flow; an empty name means the array starts at zero.
module raw_block_ram #(
   parameter int    abits     = 8,
   parameter int    lanes     = 4,
   parameter int    lane_w    = 8,
   parameter string init_file = ""
) (
   input  logic                    clk,
   input  logic                    en,
   input  logic [lanes-1:0]        we,
   input  logic [abits-1:0]        addr,
   input  logic [lanes*lane_w-1:0] wdata,
   output logic [lanes*lane_w-1:0] rdata
);

   localparam int depth = 1 << abits;
   localparam bit unused_init = (init_file != "");

   logic [lanes*lane_w-1:0] mem [depth];

   always_ff @(posedge clk) begin
      if (en) begin
         rdata <= mem[addr];
         for (int l = 0; l < lanes; l++) begin
            if (we[l]) mem[addr][l*lane_w +: lane_w] <= wdata[l*lane_w +: lane_w];
         end
      end
   end

endmodule

// File: rtl/mp_block_ram.sv
// Multi-port block RAM: several bus ports share one single-port RAM
// through a round-robin arbiter, one access per cycle.
//   abits     : log2 of the number of 32-bit words
//   ports     : number of bus ports, 1..max_ports
//   init_file : RAM initialisation file ("" = zero)
//   is_rom    : 1 accepts writes but never changes memory
//   clk       : clock, all state changes on the rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : one MEM-side boa_mem_bus per port
// ready is combinational: high when the port is granted or idle.
// rdata of the granted port shows the word the cycle after the grant
// and holds until that port is granted again.
module mp_block_ram
   import boa_pkg::*;
#(
   parameter int    abits     = 8,
   parameter int    ports     = 2,
   parameter string init_file = "",
   parameter bit    is_rom    = 1'b0
) (
   input logic     clk,
   input logic     rst_n,
   boa_mem_bus.MEM bus [ports]
);

   // Per-port views padded to max_ports so a grant_t index always
   // covers the whole array; unused slots are tied off.
   logic [max_ports-1:0] req;
   logic [abits-1:0]     word_a  [max_ports];
   logic [3:0]           we_a    [max_ports];
   logic [31:0]          wdata_a [max_ports];
   logic [31:0]          hold    [max_ports];
   logic [max_ports-1:0] unused_addr;

   grant_t     ptr;
   grant_t     gnt;
   logic       gnt_valid;
   grant_t     hi_idx;
   grant_t     lo_idx;
   logic       hi_hit;
   logic       lo_hit;
   pend_t      pend;

   logic             ram_en;
   logic [3:0]       ram_we;
   logic [abits-1:0] ram_addr;
   logic [31:0]      ram_wdata;
   logic [31:0]      ram_q;

   for (genvar p = 0; p < max_ports; p++) begin : g_port
      if (p < ports) begin : g_used
         assign req[p]     = bus[p].re | (|bus[p].we);
         assign word_a[p]  = bus[p].addr[abits+1:2];
         assign we_a[p]    = bus[p].we;
         assign wdata_a[p] = bus[p].wdata;
         // Byte offset and bits above the array alias away.
         assign unused_addr[p] = ^{bus[p].addr[31:abits+2], bus[p].addr[1:0]};
         assign bus[p].ready = ~req[p] | (gnt_valid & (gnt == grant_t'(p)));
         // The pending return is forwarded straight from the RAM so the
         // data is visible in the cycle after the grant.
         assign bus[p].rdata = (pend.valid && (pend.idx == grant_t'(p))) ? ram_q : hold[p];
      end else begin : g_unused
         assign req[p]         = 1'b0;
         assign word_a[p]      = '0;
         assign we_a[p]        = '0;
         assign wdata_a[p]     = '0;
         assign unused_addr[p] = 1'b0;
      end
   end

   // Round-robin pick: the lowest requester at or above ptr wins,
   // otherwise the lowest requester overall (the wrap-around case).
   always_comb begin
      hi_hit = 1'b0;
      hi_idx = '0;
      lo_hit = 1'b0;
      lo_idx = '0;
      for (int i = ports - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_hit = 1'b1;
            lo_idx = grant_t'(i);
            if (i >= int'(ptr)) begin
               hi_hit = 1'b1;
               hi_idx = grant_t'(i);
            end
         end
      end
      gnt_valid = lo_hit;
      gnt       = hi_hit ? hi_idx : lo_idx;
   end

   // No RAM write may happen while reset is held.
   assign ram_en    = gnt_valid & rst_n;
   assign ram_we    = (gnt_valid && !is_rom && rst_n) ? we_a[gnt] : 4'b0000;
   assign ram_addr  = word_a[gnt];
   assign ram_wdata = wdata_a[gnt];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr  <= '0;
         pend <= '0;
         for (int i = 0; i < max_ports; i++) hold[i] <= '0;
      end else begin
         if (gnt_valid) ptr <= next_ptr(gnt, ports);
         pend.valid <= gnt_valid;
         pend.idx   <= gnt;
         if (pend.valid) hold[pend.idx] <= ram_q;
      end
   end

   raw_block_ram #(
      .abits     (abits),
      .lanes     (4),
      .lane_w    (8),
      .init_file (init_file)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_q)
   );

endmodule

// File: doc/mp_block_ram.md
MP_BLOCK_RAM -- requirements
Module: mp_block_ram

Interface
REQ-001 Parameter abits, default 8: log2 of number of 32-bit words.
REQ-002 Parameter ports, default 2: number of bus ports, legal range 1..8.
REQ-003 Parameter init_file, default "": initialisation file; empty means zero-initialised.
REQ-004 Parameter is_rom, default 0: 1 discards all writes.
REQ-005 Port clk, input, 1: memory clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port bus, boa_mem_bus.MEM array [ports]: per-port re, we[3:0], addr[31:0], wdata[31:0], rdata[31:0], ready.

Function
REQ-008 Port p requests in a cycle when bus[p].re or any bus[p].we bit is high.
REQ-009 At most one request is granted per cycle; the backing RAM performs exactly that access.
REQ-010 Arbitration is round-robin: search starts at index ptr and wraps from ports-1 to 0; first requester wins.
REQ-011 After a grant to port g, ptr becomes (g+1) mod ports; with no grant, ptr holds.
REQ-012 bus[p].ready is combinational: high if port p is granted this cycle or is not requesting; low while requesting and not granted.
REQ-013 Word address is addr[abits+1:2]; addr[1:0] and bits above abits+1 are ignored (aliasing).
REQ-014 Writes are byte-masked: byte i is updated only where we[i]=1.
REQ-015 A request with re and we both set performs the write; read data returned is the pre-write word.
REQ-016 With is_rom=1, writes are accepted (ready high) but memory is never modified; rdata of the granted port still updates.
REQ-017 Read latency is 1: bus[g].rdata shows the addressed word in the cycle after the grant.
REQ-018 Each port's rdata is held in a dedicated register; it changes only in the cycle after that port is granted.
REQ-019 A register records the granted port index and a valid bit to route RAM output to the correct rdata register.
REQ-020 Back-to-back grants to different ports in consecutive cycles deliver each port's data correctly with no bubble.
REQ-021 A port holding its request unchanged after ready is treated as a new request (re-arbitrated as normal).
REQ-022 Ports=1 degenerates to a single-port RAM with ready constantly high.
REQ-023 Write followed next cycle by a read of the same word from any port returns the new data.

Reset
REQ-024 While rst_n=0: ptr=0, pending-valid=0, all rdata registers=0, no RAM write occurs.
REQ-025 Reset asserted mid-access discards any pending read return; memory contents are not cleared.
REQ-026 First grant after reset release goes to the lowest-index requester.

Structure
REQ-027 Port-count limit and grant-index width (clog2 of max ports) constants live in the shared boa package.
REQ-028 Storage is one instance of the existing raw_block_ram sub-module (abits, 4 lanes, 8 bits, init_file); arbitration and rdata routing are local logic.
REQ-029 No latches; all sequential logic uses clk and async rst_n only.

Verification
REQ-030 Reset: rst_n=0 two cycles, all ports idle -> all rdata=0, all ready=1, ptr=0.
REQ-031 Contention: ports=3, all read addr 0x10,0x14,0x18 continuously -> grants port 0,1,2,0 in order; each rdata correct one cycle after its ready.
REQ-032 Byte write: word 5 = 0x11223344, write 0xAABBCCDD with we=4'b0101 -> read returns 0x11BB33DD.
REQ-033 ROM: is_rom=1, init word 0=0xDEADBEEF, write 0 to it -> ready=1, subsequent read returns 0xDEADBEEF.
REQ-034 Aliasing: abits=4, write 0x55 at addr 0x0, read addr 0x40 -> 0x55.
REQ-035 Reset mid-read: assert rst_n low in cycle after grant -> granted port rdata=0, no stale update after release.
